// File: rtl/alu_cmd_sequencer_if.sv
// Command/response bundle for alu_cmd_sequencer.
//   master : command source and response consumer (drives cmd_*, rsp_ready)
//   slave  : the sequencer (drives cmd_ready, rsp_*)
// Signals:
//   cmd_valid/cmd_ready     command handshake
//   cmd_func, cmd_a, cmd_b  ALU function code and operands
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_flags     captured ALU result and {Shift, CMP, Logic, Arith, Carry}
//   rsp_err                 command carried an illegal function code
interface alu_cmd_sequencer_if #(
   parameter int N = 16
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_func;
   logic [N-1:0] cmd_a;
   logic [N-1:0] cmd_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_data;
   logic [4:0]   rsp_flags;
   logic         rsp_err;

   modport master (
      output cmd_valid, cmd_func, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_func, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the registered ALU: accepts one command at a time, drives the
// ALU inputs, waits the ALU latency, captures result/flags and returns them.
// Illegal function codes (4'hE, 4'hF) are answered with rsp_err and never issued.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   bus (slave)       command/response handshakes, see alu_cmd_sequencer_if
//   alu_func/a/b      registered drive to the ALU
//   alu_out/flags     ALU result and {Shift, CMP, Logic, Arith, Carry}
//   busy              high whenever the FSM is not in IDLE
//   cmd_count         completed-response counter, only with ALU_SEQ_CNT_EN
// Optional feature macro: ALU_SEQ_CNT_EN
//
// state  | meaning
// S_IDLE | cmd_ready high, waiting for a command
// S_WAIT | ALU inputs held, counting down the ALU latency
// S_RESP | response presented, waiting for rsp_ready
module alu_cmd_sequencer #(
   parameter int N       = 16,
   parameter int ALU_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_cmd_sequencer_if.slave   bus,
   output logic [3:0]           alu_func,
   output logic [N-1:0]         alu_a,
   output logic [N-1:0]         alu_b,
   input  logic [N-1:0]         alu_out,
   input  logic [4:0]           alu_flags,
   output logic                 busy
`ifdef ALU_SEQ_CNT_EN
   ,
   output logic [15:0]          cmd_count
`endif
);

   localparam logic [3:0] LAT = 4'(ALU_LAT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t       state;
   logic [3:0]   wait_cnt;
   logic         cmd_ready_q;
   logic         rsp_valid_q;
   logic [N-1:0] rsp_data_q;
   logic [4:0]   rsp_flags_q;
   logic         rsp_err_q;
   logic         illegal;

   assign illegal       = (bus.cmd_func > 4'd13);
   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign bus.rsp_err   = rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wait_cnt    <= 4'd0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= 5'd0;
         rsp_err_q   <= 1'b0;
         alu_func    <= 4'd0;
         alu_a       <= '0;
         alu_b       <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  busy        <= 1'b1;
                  if (illegal) begin
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_flags_q <= 5'd0;
                     rsp_valid_q <= 1'b1;
                     state       <= S_RESP;
                  end else begin
                     alu_func <= bus.cmd_func;
                     alu_a    <= bus.cmd_a;
                     alu_b    <= bus.cmd_b;
                     wait_cnt <= LAT;
                     state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Counter is loaded with ALU_LAT on accept, so the zero test
               // lands one edge after the ALU output became valid.
               if (wait_cnt == 4'd0) begin
                  rsp_data_q  <= alu_out;
                  rsp_flags_q <= alu_flags;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state       <= S_IDLE;
               cmd_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_CNT_EN
   logic [15:0] cmd_count_q;

   assign cmd_count = cmd_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_count_q <= 16'd0;
      end else if (rsp_valid_q && bus.rsp_ready) begin
         cmd_count_q <= cmd_count_q + 16'd1;
      end
   end
`endif

endmodule
